fp_add_normalizer: RTL and testbench

- Pipelined post-add normalization stage in the floating-point co-processor datapath.
- Consumes the 24-bit mantissa sum, its carry-out, the pre-normalization exponent and sign, and the leading-zero count produced by the 24-bit leading-one detector.
- Produces a normalized IEEE-754 single-precision sign, exponent and fraction, plus status flags.
- Two register stages with valid/ready flow control; sits between the adder/LOD stage and the result packer.

---
 rtl/fp_add_normalizer_if.sv | 35 +++
 rtl/fp_add_normalizer.sv | 210 +++++++++++++++++++++
 tb/tb_fp_add_normalizer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fp_add_normalizer_if.sv
// Handshake and data bundle between the adder/LOD stage, the post-add
// normalizer and the result packer. The slave modport is the normalizer side.
interface fp_add_normalizer_if #(
   parameter int MANT_BITS = 24,
   parameter int EXP_BITS  = 8,
   parameter int LZC_BITS  = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sign;
   logic [EXP_BITS-1:0]  in_exp;
   logic                 in_carry;
   logic [MANT_BITS-1:0] in_mant;
   logic [LZC_BITS-1:0]  in_lzc;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sign;
   logic [EXP_BITS-1:0]  out_exp;
   logic [MANT_BITS-2:0] out_frac;
   logic                 out_zero;
   logic                 out_overflow;
   logic                 out_underflow;

   modport master (
      output in_valid, in_sign, in_exp, in_carry, in_mant, in_lzc, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_frac,
             out_zero, out_overflow, out_underflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_carry, in_mant, in_lzc, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_frac,
             out_zero, out_overflow, out_underflow
   );
endinterface

// File: rtl/fp_add_normalizer.sv
// Post-add normalization: stage 1 classifies the sum and computes the shift
// amount and adjusted exponent; stage 2 shifts, saturates and registers the
// packed-ready sign/exponent/fraction with status flags. No rounding here.
module fp_add_normalizer #(
   parameter int MANT_BITS = 24,
   parameter int EXP_BITS  = 8,
   parameter int LZC_BITS  = 5
) (
   input logic                clk,
   input logic                n_rst,
   fp_add_normalizer_if.slave bus
);
   localparam int XW = EXP_BITS + 2;
   localparam logic [EXP_BITS-1:0]  EXP_MAX   = {EXP_BITS{1'b1}};
   localparam logic signed [XW-1:0] EXP_MAX_X = {2'b00, EXP_MAX};
   localparam logic signed [XW-1:0] EXP_ZERO  = {XW{1'b0}};
   localparam logic [LZC_BITS-1:0]  SH_MAX    = LZC_BITS'(MANT_BITS - 1);

   typedef enum logic [1:0] {
      MODE_NORM    = 2'd0,
      MODE_CARRY   = 2'd1,
      MODE_ZERO    = 2'd2,
      MODE_SPECIAL = 2'd3
   } mode_e;

   // stage 1 registers
   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_sign_q,  s1_sign_d;
   mode_e                s1_mode_q,  s1_mode_d;
   logic signed [XW-1:0] s1_exp_q,   s1_exp_d;
   logic [LZC_BITS-1:0]  s1_sh_q,    s1_sh_d;
   logic [MANT_BITS-1:0] s1_mant_q,  s1_mant_d;
   // stage 2 (output) registers
   logic                 s2_valid_q, s2_valid_d;
   logic                 sign_q,     sign_d;
   logic [EXP_BITS-1:0]  exp_q,      exp_d;
   logic [MANT_BITS-2:0] frac_q,     frac_d;
   logic                 zero_q,     zero_d;
   logic                 ovf_q,      ovf_d;
   logic                 unf_q,      unf_d;

   // combinational intermediates
   logic                 s1_adv;
   mode_e                cls_mode;
   logic [LZC_BITS-1:0]  cls_sh;
   logic signed [XW-1:0] cls_adj;
   logic signed [XW-1:0] cls_exp;
   logic [MANT_BITS-1:0] norm_mant;
   logic [EXP_BITS-1:0]  res_exp;
   logic [MANT_BITS-2:0] res_frac;
   logic                 res_zero, res_ovf, res_unf;

   assign s1_adv       = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s1_adv;

   // Stage 1 classification: mode, shift amount and adjusted exponent.
   always_comb begin
      cls_mode = MODE_NORM;
      cls_sh   = {LZC_BITS{1'b0}};
      cls_adj  = {XW{1'b0}};
      if (bus.in_exp == EXP_MAX) begin
         cls_mode = MODE_SPECIAL;
      end else if (!bus.in_carry && (bus.in_mant == {MANT_BITS{1'b0}})) begin
         cls_mode = MODE_ZERO;
      end else if (bus.in_carry) begin
         cls_mode = MODE_CARRY;
         cls_adj  = XW'(1);
      end else begin
         cls_mode = MODE_NORM;
         // A lone LSB has a known position; an out-of-range count is clamped.
         if ((bus.in_mant[MANT_BITS-1:1] == {(MANT_BITS-1){1'b0}}) || (bus.in_lzc > SH_MAX)) begin
            cls_sh = SH_MAX;
         end else begin
            cls_sh = bus.in_lzc;
         end
         cls_adj = -$signed({{(XW-LZC_BITS){1'b0}}, cls_sh});
      end
      cls_exp = $signed({2'b00, bus.in_exp}) + cls_adj;
   end

   // Stage 2 datapath: shift the held mantissa and saturate the exponent.
   always_comb begin
      if (s1_mode_q == MODE_CARRY) begin
         norm_mant = {1'b1, s1_mant_q[MANT_BITS-1:1]};
      end else begin
         norm_mant = s1_mant_q << s1_sh_q;
      end
      res_exp  = {EXP_BITS{1'b0}};
      res_frac = {(MANT_BITS-1){1'b0}};
      res_zero = 1'b0;
      res_ovf  = 1'b0;
      res_unf  = 1'b0;
      case (s1_mode_q)
         MODE_SPECIAL: begin
            res_exp  = EXP_MAX;
            res_frac = s1_mant_q[MANT_BITS-2:0];
         end
         MODE_ZERO: begin
            res_zero = 1'b1;
         end
         MODE_CARRY: begin
            if (s1_exp_q >= EXP_MAX_X) begin
               res_exp = EXP_MAX;
               res_ovf = 1'b1;
            end else begin
               res_exp  = s1_exp_q[EXP_BITS-1:0];
               res_frac = norm_mant[MANT_BITS-2:0];
            end
         end
         MODE_NORM: begin
            if (s1_exp_q <= EXP_ZERO) begin
               res_unf = 1'b1;
            end else begin
               res_exp  = s1_exp_q[EXP_BITS-1:0];
               res_frac = norm_mant[MANT_BITS-2:0];
            end
         end
         default: begin
            res_exp = {EXP_BITS{1'b0}};
         end
      endcase
   end

   // Next-state for both stages: load on advance, otherwise hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mode_d  = s1_mode_q;
      s1_exp_d   = s1_exp_q;
      s1_sh_d    = s1_sh_q;
      s1_mant_d  = s1_mant_q;
      s2_valid_d = s2_valid_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      frac_d     = frac_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_sign_d = bus.in_sign;
            s1_mode_d = cls_mode;
            s1_exp_d  = cls_exp;
            s1_sh_d   = cls_sh;
            s1_mant_d = bus.in_mant;
         end else begin
            s1_mant_d = s1_mant_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sign_d = s1_sign_q;
            exp_d  = res_exp;
            frac_d = res_frac;
            zero_d = res_zero;
            ovf_d  = res_ovf;
            unf_d  = res_unf;
         end else begin
            sign_d = sign_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_mode_q  <= MODE_NORM;
         s1_exp_q   <= {XW{1'b0}};
         s1_sh_q    <= {LZC_BITS{1'b0}};
         s1_mant_q  <= {MANT_BITS{1'b0}};
         s2_valid_q <= 1'b0;
         sign_q     <= 1'b0;
         exp_q      <= {EXP_BITS{1'b0}};
         frac_q     <= {(MANT_BITS-1){1'b0}};
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_mode_q  <= s1_mode_d;
         s1_exp_q   <= s1_exp_d;
         s1_sh_q    <= s1_sh_d;
         s1_mant_q  <= s1_mant_d;
         s2_valid_q <= s2_valid_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         frac_q     <= frac_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign bus.out_valid     = s2_valid_q;
   assign bus.out_sign      = sign_q;
   assign bus.out_exp       = exp_q;
   assign bus.out_frac      = frac_q;
   assign bus.out_zero      = zero_q;
   assign bus.out_overflow  = ovf_q;
   assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_fp_add_normalizer.sv
// Scoreboard bench for fp_add_normalizer: directed vectors push hand-computed
// results into a queue; a monitor pops and compares on every output transfer.
module tb_fp_add_normalizer;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [34:0] sb[$];   // {sign, exp[7:0], frac[22:0], zero, ovf, unf}

   always #5 clk = ~clk;

   fp_add_normalizer_if ifc ();
   fp_add_normalizer dut (.clk(clk), .n_rst(n_rst), .bus(ifc.slave));

   function automatic logic [34:0] ev(input logic s, input logic [7:0] e, input logic [22:0] f,
                                      input logic z, input logic o, input logic u);
      return {s, e, f, z, o, u};
   endfunction

   function automatic logic [34:0] dut_out();
      return {ifc.out_sign, ifc.out_exp, ifc.out_frac, ifc.out_zero, ifc.out_overflow, ifc.out_underflow};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // drive one beat, wait (bounded) for acceptance, record the expected result
   task automatic send(input logic s, input logic [7:0] e, input logic c, input logic [23:0] m,
                       input logic [4:0] l, input logic [34:0] exp_v);
      int n;
      n = 0;
      @(negedge clk);
      ifc.in_valid = 1'b1; ifc.in_sign = s; ifc.in_exp = e;
      ifc.in_carry = c;    ifc.in_mant = m; ifc.in_lzc = l;
      #2;
      while (!ifc.in_ready && n < 50) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!ifc.in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=in_ready_low required=accept");
      end else begin
         sb.push_back(exp_v);
      end
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      end
   endtask

   // monitor: compare on transfer, compare held outputs during stall
   initial begin
      logic [34:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (n_rst && ifc.out_valid) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual=0x%0h required=none", dut_out());
            end else if (ifc.out_ready) begin
               e = sb.pop_front();
               chk("result", 64'(dut_out()), 64'(e));
            end else begin
               chk("hold", 64'(dut_out()), 64'(sb[0]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.in_valid = 1'b0; ifc.in_sign = 1'b0; ifc.in_exp = 8'd0;
      ifc.in_carry = 1'b0; ifc.in_mant = 24'd0; ifc.in_lzc = 5'd0;
      ifc.out_ready = 1'b1;
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      #2;
      chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("rst_outputs", 64'(dut_out()), 64'd0);
      chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);

      // carry path with latency check
      send(1'b0, 8'd127, 1'b1, 24'h800001, 5'd0, ev(1'b0, 8'd128, 23'h400000, 1'b0, 1'b0, 1'b0));
      @(negedge clk); #2;
      chk("latency_cycle1_valid", 64'(ifc.out_valid), 64'd0);
      @(negedge clk); #2;
      chk("latency_cycle2_valid", 64'(ifc.out_valid), 64'd1);
      drain();

      // back-to-back directed vectors
      send(1'b1, 8'd130, 1'b0, 24'h00F000, 5'd8,  ev(1'b1, 8'd122, 23'h700000, 1'b0, 1'b0, 1'b0));
      send(1'b0, 8'd100, 1'b0, 24'h000001, 5'd0,  ev(1'b0, 8'd77,  23'h000000, 1'b0, 1'b0, 1'b0));
      send(1'b0, 8'd50,  1'b0, 24'h000003, 5'd30, ev(1'b0, 8'd27,  23'h000000, 1'b0, 1'b0, 1'b0));
      send(1'b0, 8'd254, 1'b1, 24'h000000, 5'd0,  ev(1'b0, 8'd255, 23'h000000, 1'b0, 1'b1, 1'b0));
      send(1'b1, 8'd253, 1'b1, 24'hC00000, 5'd0,  ev(1'b1, 8'd254, 23'h600000, 1'b0, 1'b0, 1'b0));
      send(1'b0, 8'd5,   1'b0, 24'h000100, 5'd15, ev(1'b0, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1));
      send(1'b0, 8'd10,  1'b0, 24'h002000, 5'd10, ev(1'b0, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1));
      send(1'b0, 8'd11,  1'b0, 24'h002000, 5'd10, ev(1'b0, 8'd1,   23'h000000, 1'b0, 1'b0, 1'b0));
      send(1'b1, 8'd80,  1'b0, 24'h000000, 5'd0,  ev(1'b1, 8'd0,   23'h000000, 1'b1, 1'b0, 1'b0));
      send(1'b0, 8'd255, 1'b0, 24'h400001, 5'd0,  ev(1'b0, 8'd255, 23'h400001, 1'b0, 1'b0, 1'b0));
      send(1'b1, 8'd255, 1'b1, 24'hFFFFFF, 5'd3,  ev(1'b1, 8'd255, 23'h7FFFFF, 1'b0, 1'b0, 1'b0));
      send(1'b0, 8'd200, 1'b0, 24'hABCDEF, 5'd0,  ev(1'b0, 8'd200, 23'h2BCDEF, 1'b0, 1'b0, 1'b0));
      drain();

      // back-pressure: two beats fill the pipe, then in_ready must drop
      @(negedge clk);
      ifc.out_ready = 1'b0;
      send(1'b0, 8'd140, 1'b0, 24'h0F0000, 5'd4,  ev(1'b0, 8'd136, 23'h700000, 1'b0, 1'b0, 1'b0));
      send(1'b1, 8'd60,  1'b1, 24'h000003, 5'd0,  ev(1'b1, 8'd61,  23'h000001, 1'b0, 1'b0, 1'b0));
      @(negedge clk); #2;
      chk("bp_in_ready_low", 64'(ifc.in_ready), 64'd0);
      fork
         send(1'b0, 8'd20, 1'b0, 24'h000010, 5'd19, ev(1'b0, 8'd1, 23'h000000, 1'b0, 1'b0, 1'b0));
         begin
            repeat (3) @(negedge clk);
            ifc.out_ready = 1'b1;
         end
      join
      send(1'b0, 8'd127, 1'b0, 24'h555555, 5'd1, ev(1'b0, 8'd126, 23'h2AAAAA, 1'b0, 1'b0, 1'b0));
      drain();

      // reset with two beats in flight: both must be discarded
      @(negedge clk);
      ifc.out_ready = 1'b0;
      send(1'b0, 8'd90, 1'b1, 24'h000002, 5'd0, ev(1'b0, 8'd91, 23'h000001, 1'b0, 1'b0, 1'b0));
      send(1'b1, 8'd90, 1'b0, 24'h800000, 5'd0, ev(1'b1, 8'd90, 23'h000000, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      n_rst = 1'b0;
      sb.delete();
      @(negedge clk); #2;
      chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
      n_rst = 1'b1;
      ifc.out_ready = 1'b1;
      repeat (6) @(negedge clk);
      #2;
      chk("midrst_no_stale", 64'(ifc.out_valid), 64'd0);

      // recovery after reset
      send(1'b1, 8'd130, 1'b0, 24'h00F000, 5'd8, ev(1'b1, 8'd122, 23'h700000, 1'b0, 1'b0, 1'b0));
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
